cim_bank_writer: RTL

Write-side sequencer for `cim_bank`: accepts a row-load command plus a valid/ready stream of 24-bit weight words and drives the bank's `D`/`WA` write port. For each row it enforces data setup, a one-hot write pulse and a data hold. Sits between the weight-load DMA/stream and one `cim_bank` instance. It is the initiator end of the `D`/`WA` interface that `cim_bank` responds to.

---
 rtl/cim_pkg.sv | 18 +
 rtl/cim_wa_decode.sv | 44 ++++
 rtl/cim_bank_writer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/cim_pkg.sv
// cim_pkg: shared types and constants for the CIM bank write path.
//   CIM_DATA_W     - default weight word width (cim_bank D width)
//   CIM_ROWS       - default number of bank rows (cim_bank WA width)
//   cim_wr_state_t - write sequencer state encoding
package cim_pkg;

  localparam int CIM_DATA_W = 24;
  localparam int CIM_ROWS   = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SETUP = 3'd2,
    ST_PULSE = 3'd3,
    ST_HOLD  = 3'd4
  } cim_wr_state_t;

endpackage

// File: rtl/cim_wa_decode.sv
// cim_wa_decode: binary row index to registered one-hot bank write address.
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-high reset (clears wa)
//   en  - when high, wa takes 1<<row at the next edge; otherwise wa clears
//   row - binary row index (0..ROWS-1)
//   wa  - registered one-hot write address, all-zero when not enabled
module cim_wa_decode
  import cim_pkg::*;
#(
  parameter int ROWS = CIM_ROWS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [$clog2(ROWS)-1:0] row,
  output logic [ROWS-1:0]         wa
);

  logic [ROWS-1:0] wa_d;
  logic [ROWS-1:0] wa_q;

  // One-hot decode of the row index, gated by the enable.
  always_comb begin
    wa_d = '0;
    if (en) begin
      wa_d[row] = 1'b1;
    end else begin
      wa_d = '0;
    end
  end

  // Write-address register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wa_q <= '0;
    end else begin
      wa_q <= wa_d;
    end
  end

  assign wa = wa_q;

endmodule

// File: rtl/cim_bank_writer.sv
// cim_bank_writer: write-side sequencer for cim_bank.
// Accepts a row-load command (cmd_row, cmd_len) and a valid/ready stream of
// weight words. For every row it fetches one word, holds it on D with WA=0
// (setup), raises one WA bit (pulse), then holds D with WA=0 again (hold).
// Ports:
//   clk, rst            - clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready - load command handshake (ready only in IDLE)
//   cmd_row, cmd_len    - first row, row count (0 = no-op, >ROWS clamped)
//   s_valid/s_ready     - weight stream handshake (ready only in FETCH)
//   s_data              - weight word
//   D, WA               - registered bank data / one-hot write address
//   busy                - sequencer not idle
//   done                - one-cycle pulse when a command completes
//   wr_count            - saturating count of completed pulses; present only
//                         when CIM_BANK_WRITER_CNT_EN is defined
module cim_bank_writer
  import cim_pkg::*;
#(
  parameter int DATA_W    = CIM_DATA_W,
  parameter int ROWS      = CIM_ROWS,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [$clog2(ROWS)-1:0] cmd_row,
  input  logic [$clog2(ROWS):0]   cmd_len,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_W-1:0]       s_data,
  output logic [DATA_W-1:0]       D,
  output logic [ROWS-1:0]         WA,
  output logic                    busy,
  output logic                    done
`ifdef CIM_BANK_WRITER_CNT_EN
  ,
  output logic [15:0]             wr_count
`endif
);

  localparam int RW      = $clog2(ROWS);
  localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC)
                           ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                           : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
  // The counter holds (phase length - 1), so clog2(MAX_CYC) bits suffice.
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [RW:0]      ROWS_LEN = (RW+1)'(ROWS);
  localparam logic [RW-1:0]    LAST_ROW = RW'(ROWS - 1);

  cim_wr_state_t     state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [RW-1:0]     row_d, row_q;
  logic [RW:0]       rem_d, rem_q;
  logic [DATA_W-1:0] d_d, d_q;
  logic              done_d, done_q;
  logic              wa_en;
  logic [RW:0]       len_clamped;

  assign len_clamped = (cmd_len > ROWS_LEN) ? ROWS_LEN : cmd_len;

  // Next-state, phase counter and datapath updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    rem_d   = rem_q;
    d_d     = d_q;
    done_d  = 1'b0;
    wa_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          row_d = cmd_row;
          rem_d = len_clamped;
          if (len_clamped != '0) begin
            state_d = ST_FETCH;
          end else begin
            // Zero-length command completes without leaving IDLE.
            done_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (s_valid) begin
          d_d     = s_data;
          cnt_d   = SETUP_LD;
          state_d = ST_SETUP;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = PULSE_LD;
          state_d = ST_PULSE;
          wa_en   = 1'b1;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          cnt_d   = HOLD_LD;
          state_d = ST_HOLD;
        end else begin
          // WA is registered, so keep the enable up while PULSE continues.
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
          wa_en = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          rem_d = rem_q - {{RW{1'b0}}, 1'b1};
          if (row_q == LAST_ROW) begin
            row_d = '0;
          end else begin
            row_d = row_q + {{(RW-1){1'b0}}, 1'b1};
          end
          if (rem_q == {{RW{1'b0}}, 1'b1}) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      rem_q   <= '0;
      d_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      rem_q   <= rem_d;
      d_q     <= d_d;
      done_q  <= done_d;
    end
  end

  cim_wa_decode #(
    .ROWS (ROWS)
  ) u_wa_decode (
    .clk (clk),
    .rst (rst),
    .en  (wa_en),
    .row (row_q),
    .wa  (WA)
  );

  assign D         = d_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);
  assign cmd_ready = (state_q == ST_IDLE);
  assign s_ready   = (state_q == ST_FETCH);

`ifdef CIM_BANK_WRITER_CNT_EN
  logic        pulse_end;
  logic [15:0] wr_count_d, wr_count_q;

  assign pulse_end = (state_q == ST_PULSE) && (cnt_q == '0);

  // Saturating count of completed write pulses.
  always_comb begin
    wr_count_d = wr_count_q;
    if (pulse_end && (wr_count_q != 16'hFFFF)) begin
      wr_count_d = wr_count_q + 16'd1;
    end else begin
      wr_count_d = wr_count_q;
    end
  end

  // Pulse counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_q <= 16'd0;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count = wr_count_q;
`endif

endmodule
